// File: rtl/key_detect.sv
// key_detect: debounces one active-low push-button pin and reports
// a clean level plus a one-cycle strobe on each confirmed press/release.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   reset      synchronous, active-low reset
//   key        raw button pin, asynchronous (1 = released, 0 = pressed)
//   key_state  debounced level (1 = released, 0 = pressed)
//   key_flag   one-cycle pulse when a press or a release is confirmed
module key_detect #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W           = 20
) (
   input  logic clk,
   input  logic reset,
   input  logic key,
   output logic key_state,
   output logic key_flag
);

   typedef enum logic [1:0] {
      IDLE,
      FILT_DN,
      DOWN,
      FILT_UP
   } state_t;

   localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             key_state_nxt;
   logic             key_flag_nxt;
   logic             s1;
   logic             s2;
   logic             s3;
   logic [1:0]       settle;
   logic             armed;
   logic             nedge;
   logic             pedge;
   logic             term;

   // The sync chain resets to 1, so a pin held low across reset would
   // look like a falling edge once the chain refills. Edges are ignored
   // until the chain holds real samples, so such a press is not reported.
   assign armed = (settle == 2'd3);
   assign nedge = armed & s3 & ~s2;
   assign pedge = armed & ~s3 & s2;
   assign term  = (cnt == TERM);

   always_ff @(posedge clk) begin
      if (!reset) begin
         s1        <= 1'b1;
         s2        <= 1'b1;
         s3        <= 1'b1;
         settle    <= 2'd0;
         state     <= IDLE;
         cnt       <= '0;
         key_state <= 1'b1;
         key_flag  <= 1'b0;
      end else begin
         s1        <= key;
         s2        <= s1;
         s3        <= s2;
         if (!armed) begin
            settle <= settle + 2'd1;
         end
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         key_state <= key_state_nxt;
         key_flag  <= key_flag_nxt;
      end
   end

   // In the filter states an opposing edge wins over terminal count,
   // so an edge landing on the last cycle still restarts the window.
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      key_state_nxt = key_state;
      key_flag_nxt  = 1'b0;
      unique case (state)
         IDLE: begin
            if (nedge) begin
               state_nxt = FILT_DN;
               cnt_nxt   = '0;
            end
         end
         FILT_DN: begin
            if (pedge) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (term) begin
               state_nxt     = DOWN;
               cnt_nxt       = '0;
               key_state_nxt = 1'b0;
               key_flag_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         DOWN: begin
            if (pedge) begin
               state_nxt = FILT_UP;
               cnt_nxt   = '0;
            end
         end
         FILT_UP: begin
            if (nedge) begin
               state_nxt = DOWN;
               cnt_nxt   = '0;
            end else if (term) begin
               state_nxt     = IDLE;
               cnt_nxt       = '0;
               key_state_nxt = 1'b1;
               key_flag_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_key_detect.sv
// tb_key_detect: randomized bounce stimulus against a timing reference
// model; expected flag events are queued and checked by a monitor.
module tb_key_detect;

   localparam int D = 40;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic key = 1'b1;
   logic key_state;
   logic key_flag;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int n_exp = 0;
   int n_seen = 0;

   typedef struct {
      int   due;
      logic lvl;
   } exp_t;

   exp_t q[$];

   logic       lvl_m = 1'b1;
   logic [3:0] smp = 4'hf;
   int         nval = 0;
   logic       pend = 1'b0;
   logic       ptgt = 1'b0;
   int         due = 0;
   logic       prev_flag = 1'b0;

   key_detect #(
      .DEBOUNCE_CYCLES(D),
      .CNT_W(6)
   ) dut (
      .clk(clk),
      .reset(reset),
      .key(key),
      .key_state(key_state),
      .key_flag(key_flag)
   );

   always #10 clk = ~clk;

   // Reference: the pin is seen two clocks late; a change away from the
   // accepted level is accepted once it has stood for D clocks, and any
   // further change (including on the last clock) cancels it.
   always @(posedge clk) begin
      cyc++;
      if (!reset) begin
         lvl_m = 1'b1;
         nval  = 0;
         pend  = 1'b0;
      end else begin
         smp = {smp[2:0], key};
         if (nval < 4) nval++;
         if (nval == 4 && smp[2] != smp[3]) begin
            if (smp[2] != lvl_m) begin
               pend = 1'b1;
               ptgt = smp[2];
               due  = cyc + D;
            end else begin
               pend = 1'b0;
            end
         end else if (pend && cyc == due) begin
            lvl_m = ptgt;
            pend  = 1'b0;
            q.push_back('{cyc, ptgt});
            n_exp++;
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      total++;
      if (key_state !== lvl_m) begin
         bad++;
         if (bad < 20)
            $display("FAIL level cyc=%0d got=%b want=%b",
                     cyc, key_state, lvl_m);
      end
      if (q.size() > 0 && q[0].due < cyc) begin
         e = q.pop_front();
         total++;
         bad++;
         $display("FAIL missing_flag due=%0d got=none want=pulse", e.due);
      end
      if (key_flag === 1'b1) begin
         n_seen++;
         total++;
         if (prev_flag) begin
            bad++;
            $display("FAIL double_flag cyc=%0d got=2 want=1", cyc);
         end
         if (q.size() == 0) begin
            bad++;
            $display("FAIL spurious_flag cyc=%0d got=1 want=0", cyc);
         end else begin
            e = q.pop_front();
            if (e.due != cyc || key_state !== e.lvl) begin
               bad++;
               $display("FAIL flag_event got=cyc%0d/%b want=cyc%0d/%b",
                        cyc, key_state, e.due, e.lvl);
            end
         end
      end else if (key_flag !== 1'b0) begin
         total++;
         bad++;
         $display("FAIL flag_x cyc=%0d got=%b want=0", cyc, key_flag);
      end
      prev_flag = (key_flag === 1'b1);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bounce(input int n);
      for (int i = 0; i < n; i++) begin
         key = ~key;
         tick(int'($urandom_range(D - 5, 1)));
      end
   endtask

   initial begin
      // reset with key released
      reset = 1'b0;
      key   = 1'b1;
      tick(10);
      reset = 1'b1;
      tick(5);
      // press bounce then stable press
      bounce(50);
      key = 1'b0;
      tick(3 * D);
      // release bounce then stable release
      bounce(50);
      key = 1'b1;
      tick(3 * D);
      // back-to-back press/release cycles
      for (int k = 0; k < 4; k++) begin
         bounce(10);
         key = 1'b0;
         tick(2 * D);
         bounce(10);
         key = 1'b1;
         tick(2 * D);
      end
      // pulses at and just under the window: rejected
      key = 1'b0;
      tick(D);
      key = 1'b1;
      tick(3 * D);
      key = 1'b0;
      tick(D - 1);
      key = 1'b1;
      tick(3 * D);
      // one clock over the window: accepted, then released
      key = 1'b0;
      tick(D + 1);
      key = 1'b1;
      tick(3 * D);
      // reset in the middle of a stable press
      key = 1'b0;
      tick(D / 2);
      reset = 1'b0;
      tick(5);
      reset = 1'b1;
      tick(3 * D);
      key = 1'b1;
      tick(3 * D);
      key = 1'b0;
      tick(3 * D);
      key = 1'b1;
      tick(3 * D);

      total++;
      if (n_seen != 14) begin
         bad++;
         $display("FAIL flag_count got=%0d want=14", n_seen);
      end
      total++;
      if (n_exp != 14) begin
         bad++;
         $display("FAIL model_count got=%0d want=14", n_exp);
      end
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL pending got=%0d want=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
